// File: rtl/e203_extend_csr_pkg.sv
// ----------------------------------------------------------------------------
// e203_extend_csr_pkg
// Shared definitions for the extended-CSR arbiter slice:
//   state_t  : arbiter FSM states (IDLE / BUSY / RESP)
//   NUM_REQ  : number of upstream requesters
//   DATA_W   : CSR address / data width
// ----------------------------------------------------------------------------
package e203_extend_csr_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/e203_extend_csr_rr.sv
// ----------------------------------------------------------------------------
// e203_extend_csr_rr
// Two-way round-robin picker. Purely combinational.
//   req   : request bits, one per requester
//   last  : index of the requester granted most recently
//   grant : index of the requester that wins now (don't-care when req == 0)
// ----------------------------------------------------------------------------
module e203_extend_csr_rr
    import e203_extend_csr_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               grant
);

    always_comb begin
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;   // contention: the one not served last wins
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/e203_extend_csr_arb.sv
// ----------------------------------------------------------------------------
// e203_extend_csr_arb
// Arbitrates two CSR requesters onto one downstream NICE CSR port, one
// transaction at a time, with an optional BUSY timeout.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : per-requester request handshake
//   req_addr/wr/wdata : per-requester request fields (requester i at [32i+:32])
//   rsp_valid/ready   : per-requester response handshake
//   rsp_rdata/err     : shared response data and timeout flag
//   nice_csr_*        : downstream request / response port
// Parameter TMO_CYC: BUSY cycles without nice_csr_ready before abort (0 = off).
// ----------------------------------------------------------------------------
module e203_extend_csr_arb
    import e203_extend_csr_pkg::*;
#(
    parameter int unsigned TMO_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        nice_csr_valid,
    input  logic                        nice_csr_ready,
    output logic [DATA_W-1:0]           nice_csr_addr,
    output logic                        nice_csr_wr,
    output logic [DATA_W-1:0]           nice_csr_wdata,
    input  logic [DATA_W-1:0]           nice_csr_rdata
);

    localparam int CNT_RAW = $clog2(TMO_CYC + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, wdata_q, rdata_q;
    logic                wr_q, err_q;
    logic                grant_q;
    logic                last_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                pick;
    logic                any_req;
    logic                tmo_hit;
    logic                rsp_hs;

    e203_extend_csr_rr u_rr (
        .req   (req_valid),
        .last  (last_q),
        .grant (pick)
    );

    assign any_req = |req_valid;
    assign tmo_hit = (TMO_CYC != 0) && (cnt_q == TMO_LAST) && !nice_csr_ready;
    assign rsp_hs  = rsp_ready[grant_q];   // the non-granted ready bit is ignored

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_BUSY;
            ST_BUSY: if (nice_csr_ready || tmo_hit) state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: every output is qualified by its owning state, so all of
    // them read 0 while reset holds the FSM in IDLE. req_ready also looks at
    // rst directly because in IDLE it follows req_valid combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready      = '0;
        nice_csr_valid = 1'b0;
        nice_csr_addr  = '0;
        nice_csr_wr    = 1'b0;
        nice_csr_wdata = '0;
        rsp_valid      = '0;
        rsp_rdata      = '0;
        rsp_err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req && !rst) req_ready = pick ? 2'b10 : 2'b01;
            end
            ST_BUSY: begin
                nice_csr_valid = 1'b1;
                nice_csr_addr  = addr_q;
                nice_csr_wr    = wr_q;
                nice_csr_wdata = wdata_q;
            end
            ST_RESP: begin
                rsp_valid = grant_q ? 2'b10 : 2'b01;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction datapath
    // ------------------------------------------------------------------------
    // NOTE: these are plain registers, not a memory array, so each one gets
    // an explicit reset value; reset mid-transaction leaves nothing stale.
    // last_q resets to 1 so that requester 0 holds priority out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= pick;
                        addr_q  <= pick ? req_addr[2*DATA_W-1:DATA_W]  : req_addr[DATA_W-1:0];
                        wdata_q <= pick ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        wr_q    <= req_wr[pick];
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (nice_csr_ready) begin
                        // Ready beats a coincident timeout.
                        rdata_q <= nice_csr_rdata;
                        err_q   <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) last_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

endmodule
